spram_arb: RTL and testbench

SPRAM_ARB -- requirements
Module: spram_arb

---
 rtl/spram_arb.sv | 109 ++++++++++
 tb/tb_spram_arb.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_arb.sv
// Two-port round-robin arbiter in front of a synchronous single-port RAM.
// Define SPRAM_ARB_FIXED_PRIO_EN to make port 0 win every tie.
module spram_arb #(
    parameter int unsigned aw = 10,
    parameter int unsigned dw = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [aw-1:0] p0_addr,
    input  logic [dw-1:0] p0_di,
    output logic          p0_ack,
    output logic [dw-1:0] p0_do,
    output logic          p0_rvalid,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [aw-1:0] p1_addr,
    input  logic [dw-1:0] p1_di,
    output logic          p1_ack,
    output logic [dw-1:0] p1_do,
    output logic          p1_rvalid,
    output logic          ram_ce,
    output logic          ram_we,
    output logic          ram_oe,
    output logic [aw-1:0] ram_addr,
    output logic [dw-1:0] ram_di,
    input  logic [dw-1:0] ram_do
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t state;
    logic   last_grant;
    logic   grant;
    logic   lat_we;
    logic   pick1;

    always_comb begin
        pick1 = 1'b0;
`ifdef SPRAM_ARB_FIXED_PRIO_EN
        pick1 = p1_req && !p0_req;
`else
        // on a tie the port that did not win last time is served
        pick1 = p1_req && (!p0_req || !last_grant);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            lat_we     <= 1'b0;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            p0_rvalid  <= 1'b0;
            p1_rvalid  <= 1'b0;
            p0_do      <= '0;
            p1_do      <= '0;
            ram_ce     <= 1'b0;
            ram_we     <= 1'b0;
            ram_oe     <= 1'b0;
            ram_addr   <= '0;
            ram_di     <= '0;
        end else begin
            p0_ack    <= 1'b0;
            p1_ack    <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            ram_ce    <= 1'b0;
            ram_we    <= 1'b0;
            ram_oe    <= 1'b0;
            case (state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        grant      <= pick1;
                        last_grant <= pick1;
                        lat_we     <= pick1 ? p1_we : p0_we;
                        ram_addr   <= pick1 ? p1_addr : p0_addr;
                        ram_di     <= pick1 ? p1_di : p0_di;
                        // RAM strobes and ack are registered here so they appear in ISSUE
                        ram_ce     <= 1'b1;
                        ram_oe     <= 1'b1;
                        ram_we     <= pick1 ? p1_we : p0_we;
                        p0_ack     <= !pick1;
                        p1_ack     <= pick1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= lat_we ? IDLE : CAPTURE;
                end
                CAPTURE: begin
                    if (grant) begin
                        p1_do     <= ram_do;
                        p1_rvalid <= 1'b1;
                    end else begin
                        p0_do     <= ram_do;
                        p0_rvalid <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spram_arb.sv
// Self-checking bench for spram_arb: directed vector table, hand-written corner
// sequences and a randomized run against a transaction-schedule reference model.
module tb_spram_arb;
    localparam int AW = 10;
    localparam int DW = 32;

`ifdef SPRAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          p0_req = 1'b0, p0_we = 1'b0;
    logic [AW-1:0] p0_addr = '0;
    logic [DW-1:0] p0_di = '0;
    logic          p0_ack, p0_rvalid;
    logic [DW-1:0] p0_do;
    logic          p1_req = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p1_addr = '0;
    logic [DW-1:0] p1_di = '0;
    logic          p1_ack, p1_rvalid;
    logic [DW-1:0] p1_do;
    logic          ram_ce, ram_we, ram_oe;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_di;
    logic [DW-1:0] ram_do = '0;

    int checks = 0;
    int errors = 0;

    spram_arb #(.aw(AW), .dw(DW)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_di(p0_di),
        .p0_ack(p0_ack), .p0_do(p0_do), .p0_rvalid(p0_rvalid),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_di(p1_di),
        .p1_ack(p1_ack), .p1_do(p1_do), .p1_rvalid(p1_rvalid),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do)
    );

    always #5 clk = ~clk;

    // synchronous single-port RAM with a known power-up pattern
    function automatic logic [DW-1:0] init_val(input int unsigned a);
        if (a == 0) return '0;
        if (a == 1023) return 32'h12345678;
        return a * 32'h9E3779B1;
    endfunction

    logic [DW-1:0] mem [1<<AW];
    bit            written [1<<AW];
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) begin
                mem[ram_addr]     <= ram_di;
                written[ram_addr] <= 1'b1;
            end else begin
                ram_do <= written[ram_addr] ? mem[ram_addr] : init_val(int'(ram_addr));
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_port(input bit p, input bit req, input bit we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] di);
        if (p) begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_di = di;
        end else begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_di = di;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        bit            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] di;
        logic [DW-1:0] do0;
        logic [DW-1:0] do1;
    } vec_t;

    // single transaction from the IDLE cycle T: ack at T+1, rvalid at T+3
    task automatic run_row(input vec_t v);
        set_port(v.port, 1'b1, v.we, v.addr, v.di);
        @(negedge clk);
        chk("row_ack", {62'd0, p1_ack, p0_ack}, v.port ? 64'd2 : 64'd1);
        chk("row_ram_ctl", {61'd0, ram_ce, ram_oe, ram_we}, {61'd0, 2'b11, v.we});
        chk("row_ram_addr", {54'd0, ram_addr}, {54'd0, v.addr});
        if (v.we) chk("row_ram_di", {32'd0, ram_di}, {32'd0, v.di});
        set_port(v.port, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("row_ce_one_cycle", {59'd0, ram_ce, ram_oe, ram_we, p1_ack, p0_ack}, 64'd0);
        if (!v.we) begin
            chk("row_rvalid_early", {62'd0, p1_rvalid, p0_rvalid}, 64'd0);
            @(negedge clk);
            chk("row_rvalid", {62'd0, p1_rvalid, p0_rvalid}, v.port ? 64'd2 : 64'd1);
            chk("row_ce_idle", {63'd0, ram_ce}, 64'd0);
        end
        chk("row_do", {p1_do, p0_do}, {v.do1, v.do0});
    endtask

    vec_t tbl[6];

    // reference model state for the randomized run
    logic [DW-1:0] shadow [1<<AW];

    initial begin
        tbl[0] = '{1'b0, 1'b1, 10'h005, 32'hDEADBEEF, 32'h0,        32'h0};
        tbl[1] = '{1'b0, 1'b0, 10'h005, 32'h0,        32'hDEADBEEF, 32'h0};
        tbl[2] = '{1'b1, 1'b0, 10'h010, 32'h0,        32'hDEADBEEF, 32'hA};
        tbl[3] = '{1'b1, 1'b0, 10'h011, 32'h0,        32'hDEADBEEF, 32'hB};
        tbl[4] = '{1'b1, 1'b0, 10'h3FF, 32'h0,        32'hDEADBEEF, 32'h12345678};
        tbl[5] = '{1'b0, 1'b0, 10'h000, 32'h0,        32'h0,        32'h12345678};

        // reset values
        #2;
        chk("reset_outputs", {57'd0, p0_ack, p1_ack, p0_rvalid, p1_rvalid, ram_ce, ram_we, ram_oe}, 64'd0);
        chk("reset_do", {p1_do, p0_do}, 64'd0);
        chk("reset_ram_bus", {22'd0, ram_addr, ram_di}, 64'd0);
        do_reset();

        // idle: ten cycles with no request
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_quiet", {57'd0, p0_ack, p1_ack, p0_rvalid, p1_rvalid, ram_ce, ram_we, ram_oe}, 64'd0);
        end

        // back-to-back p1 writes, req held high across both
        set_port(1'b1, 1'b1, 1'b1, 10'h010, 32'hA);
        @(negedge clk);
        chk("b2b_ack0", {62'd0, p1_ack, p0_ack}, 64'd2);
        chk("b2b_bus0", {22'd0, ram_addr, ram_di}, {22'd0, 10'h010, 32'hA});
        set_port(1'b1, 1'b1, 1'b1, 10'h011, 32'hB);
        @(negedge clk);
        chk("b2b_gap", {62'd0, p1_ack, ram_ce}, 64'd0);
        @(negedge clk);
        chk("b2b_ack1", {62'd0, p1_ack, p0_ack}, 64'd2);
        chk("b2b_bus1", {22'd0, ram_addr, ram_di}, {22'd0, 10'h011, 32'hB});
        chk("b2b_we", {63'd0, ram_we}, 64'd1);
        set_port(1'b1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("b2b_done", {62'd0, p1_ack, ram_ce}, 64'd0);

        foreach (tbl[i]) run_row(tbl[i]);

        // both ports hold a read request from reset: grants alternate (or p0 only)
        do_reset();
        set_port(1'b0, 1'b1, 1'b0, 10'h005, '0);
        set_port(1'b1, 1'b1, 1'b0, 10'h3FF, '0);
        for (int k = 1; k <= 14; k++) begin
            bit ea0, ea1, ev0, ev1;
            int j;
            @(negedge clk);
            ea0 = 0; ea1 = 0; ev0 = 0; ev1 = 0;
            if (k <= 10 && k % 3 == 1) begin
                j = k / 3;
                if (FIXED || j % 2 == 0) ea0 = 1; else ea1 = 1;
            end
            if (k <= 12 && k >= 3 && k % 3 == 0) begin
                j = (k - 3) / 3;
                if (FIXED || j % 2 == 0) ev0 = 1; else ev1 = 1;
            end
            chk("tie_ack", {62'd0, p1_ack, p0_ack}, {62'd0, ea1, ea0});
            chk("tie_rvalid", {62'd0, p1_rvalid, p0_rvalid}, {62'd0, ev1, ev0});
            if (ev0) chk("tie_do0", {32'd0, p0_do}, 64'hDEADBEEF);
            if (ev1) chk("tie_do1", {32'd0, p1_do}, 64'h12345678);
            if (k == 12) begin
                set_port(1'b0, 1'b0, 1'b0, '0, '0);
                set_port(1'b1, 1'b0, 1'b0, '0, '0);
            end
        end

        // reset during CAPTURE of a p1 read aborts it
        set_port(1'b1, 1'b1, 1'b0, 10'h3FF, '0);
        @(negedge clk);
        chk("abort_ack", {62'd0, p1_ack, p0_ack}, 64'd2);
        set_port(1'b1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_async", {60'd0, p1_rvalid, p0_rvalid, ram_ce, p1_ack}, 64'd0);
        chk("abort_do", {p1_do, p0_do}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        chk("abort_no_rvalid", {62'd0, p1_rvalid, p0_rvalid}, 64'd0);
        @(negedge clk);
        chk("abort_still_quiet", {59'd0, p1_rvalid, p0_rvalid, p1_ack, p0_ack, ram_ce}, 64'd0);
        chk("abort_do_zero", {32'd0, p1_do}, 64'd0);
        set_port(1'b0, 1'b1, 1'b0, 10'h005, '0);
        set_port(1'b1, 1'b1, 1'b0, 10'h3FF, '0);
        @(negedge clk);
        chk("abort_tie_p0", {62'd0, p1_ack, p0_ack}, 64'd1);
        set_port(1'b0, 1'b0, 1'b0, '0, '0);
        set_port(1'b1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_after_rvalid", {62'd0, p1_rvalid, p0_rvalid}, 64'd1);
        chk("abort_after_do", {p1_do, p0_do}, {32'd0, 32'hDEADBEEF});

        // randomized traffic against a transaction-schedule model
        do_reset();
        for (int i = 0; i < (1 << AW); i++)
            shadow[i] = written[i] ? mem[i] : init_val(i);
        begin
            bit            rq [2];
            bit            rwe [2];
            logic [AW-1:0] raddr [2];
            logic [DW-1:0] rdi [2];
            logic [DW-1:0] exp_do [2];
            int            free_cyc = 0, ack_cyc = -1, rv_cyc = -1;
            bit            ack_port = 0, rv_port = 0, ack_we = 0, last = 1;
            logic [DW-1:0] rv_data = '0;
            logic [AW-1:0] e_addr = '0;
            logic [DW-1:0] e_di = '0;
            bit            g, ce, ackv [2];
            rq = '{0, 0};
            exp_do = '{'0, '0};
            for (int k = 0; k < 2000; k++) begin
                if (k > 0) @(negedge clk);
                ce = (k == ack_cyc);
                if (k == rv_cyc) exp_do[rv_port] = rv_data;
                chk("rnd_ack", {62'd0, p1_ack, p0_ack},
                    {62'd0, ce && ack_port, ce && !ack_port});
                chk("rnd_rvalid", {62'd0, p1_rvalid, p0_rvalid},
                    {62'd0, k == rv_cyc && rv_port, k == rv_cyc && !rv_port});
                chk("rnd_ram_ctl", {61'd0, ram_ce, ram_oe, ram_we}, {61'd0, ce, ce, ce && ack_we});
                chk("rnd_ram_bus", {22'd0, ram_addr, ram_di}, {22'd0, e_addr, e_di});
                chk("rnd_do", {p1_do, p0_do}, {exp_do[1], exp_do[0]});
                // requesters hold until acked, then may start again later
                ackv[0] = p0_ack;
                ackv[1] = p1_ack;
                for (int p = 0; p < 2; p++) begin
                    if (rq[p]) begin
                        if (ackv[p]) rq[p] = 0;
                    end else if ($urandom_range(0, 2) == 0) begin
                        rq[p]    = 1;
                        rwe[p]   = ($urandom_range(0, 2) == 0);
                        raddr[p] = ($urandom_range(0, 7) == 0) ? AW'(1023) : AW'($urandom_range(0, 31));
                        rdi[p]   = $urandom;
                    end
                    set_port(p[0], rq[p], rq[p] ? rwe[p] : 1'b0,
                             rq[p] ? raddr[p] : '0, rq[p] ? rdi[p] : '0);
                end
                if (k >= free_cyc && (rq[0] || rq[1])) begin
                    if (rq[0] && rq[1]) g = FIXED ? 1'b0 : !last;
                    else g = rq[1];
                    last     = g;
                    ack_cyc  = k + 1;
                    ack_port = g;
                    ack_we   = rwe[g];
                    e_addr   = raddr[g];
                    e_di     = rdi[g];
                    if (rwe[g]) begin
                        shadow[raddr[g]] = rdi[g];
                        free_cyc = k + 2;
                    end else begin
                        rv_cyc   = k + 3;
                        rv_port  = g;
                        rv_data  = shadow[raddr[g]];
                        free_cyc = k + 3;
                    end
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
